// File: rtl/uartb_burst_rx.sv
// 8N1 UART receiver with optional 4-byte little-endian burst packing into a 32-bit word.
// q/dv/ovf/ferr update one cycle after the stop-bit sample; no backpressure, a word landing on dv=1 sets ovf.
module uartb_burst_rx #(
  parameter int unsigned DIV_RST     = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic [9:0]  d,
  input  logic        wrbaud,
  input  logic        rd,
  output logic [31:0] q,
  output logic        dv,
  output logic        ovf,
  output logic        ferr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   rxd_s;
  logic                   fall;

  logic [8:0]  n_q;
  logic        mode_q;
  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] q_q, q_d;
  logic        dv_q, dv_d;
  logic        ovf_q, ovf_d;
  logic        ferr_q, ferr_d;

  logic        stop_ok;
  logic        stop_bad;
  logic        done;
  logic [31:0] word;

  assign rxd_s = sync_q[SYNC_STAGES-1];
  // Edge detection stays disarmed until a genuine high has crossed the synchroniser,
  // so a line held low through reset release never looks like a start bit.
  assign fall  = armed_q && prev_q && !rxd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      fill_q  <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= rxd_s;
      if (fill_q[SYNC_STAGES-1] && rxd_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= DIV_RST[8:0];
      mode_q <= 1'b0;
    end else if (wrbaud) begin
      n_q    <= (d[8:0] < 9'd3) ? 9'd3 : d[8:0];
      mode_q <= d[9];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    done     = 1'b0;
    word     = {24'h0, sh_q};

    case (state_q)
      IDLE: begin
        if (fall) begin
          cnt_d   = n_q >> 1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 9'd0) begin
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            cnt_d   = n_q;
            bit_d   = 3'd0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      DATA: begin
        if (cnt_q == 9'd0) begin
          sh_d  = {rxd_s, sh_q[7:1]};
          cnt_d = n_q;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      STOP: begin
        if (cnt_q == 9'd0) begin
          state_d  = IDLE;
          stop_ok  = rxd_s;
          stop_bad = !rxd_s;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop_ok) begin
      if (!mode_q) begin
        done = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0: asm_d[7:0]   = sh_q;
          2'd1: asm_d[15:8]  = sh_q;
          2'd2: asm_d[23:16] = sh_q;
          default: begin
            done  = 1'b1;
            word  = {sh_q, asm_q};
            asm_d = '0;
          end
        endcase
      end
    end

    if (stop_bad) begin
      idx_d = 2'd0;
      asm_d = '0;
    end

    // A divider write abandons whatever frame or burst was in flight.
    if (wrbaud) begin
      state_d  = IDLE;
      idx_d    = 2'd0;
      asm_d    = '0;
      done     = 1'b0;
      stop_bad = 1'b0;
    end
  end

  always_comb begin
    q_d    = q_q;
    dv_d   = dv_q;
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (rd) begin
      dv_d   = 1'b0;
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (done) begin
      if (!dv_q || rd) begin
        q_d  = word;
        dv_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (stop_bad) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      q_q     <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      q_q     <= q_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign q    = q_q;
  assign dv   = dv_q;
  assign ovf  = ovf_q;
  assign ferr = ferr_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uartb_burst_rx.sv
// Bench for uartb_burst_rx: directed scenarios plus randomized frames against a queue-based model.
module tb_uartb_burst_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxd;
  logic [9:0]  d;
  logic        wrbaud;
  logic        rd;
  logic [31:0] q;
  logic        dv, ovf, ferr, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_eff  = 7;
  bit rd_rand = 1'b0;
  int rd_at   = -1;

  // Behavioural model state
  logic [31:0] m_q;
  bit          m_dv, m_ovf, m_ferr, m_mode;
  int          m_idx;
  logic [7:0]  m_lane [4];
  int          ev_cyc  [$];
  logic [7:0]  ev_byte [$];
  bit          ev_ok   [$];
  int          win_s   [$];
  int          win_e   [$];
  bit          rd_prev, wb_prev;
  logic [9:0]  d_prev;

  bit          mb_done, mb_bad, mb_ok, exp_busy;
  logic [31:0] mb_word;
  logic [7:0]  mb_byte;

  uartb_burst_rx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxd    (rxd),
    .d      (d),
    .wrbaud (wrbaud),
    .rd     (rd),
    .q      (q),
    .dv     (dv),
    .ovf    (ovf),
    .ferr   (ferr),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: apply everything the DUT sampled on posedge number cyc, then compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_q = '0; m_dv = 0; m_ovf = 0; m_ferr = 0; m_mode = 0; m_idx = 0;
      ev_cyc.delete(); ev_byte.delete(); ev_ok.delete();
      win_s.delete(); win_e.delete();
    end else begin
      mb_done = 0; mb_bad = 0; mb_word = '0;
      if (wb_prev) begin
        m_mode = d_prev[9];
        m_idx  = 0;
      end
      while (ev_cyc.size() > 0 && ev_cyc[0] <= cyc) begin
        void'(ev_cyc.pop_front());
        mb_byte = ev_byte.pop_front();
        mb_ok   = ev_ok.pop_front();
        if (!mb_ok) begin
          mb_bad = 1;
          m_idx  = 0;
        end else if (!m_mode) begin
          mb_done = 1;
          mb_word = {24'h0, mb_byte};
        end else begin
          m_lane[m_idx] = mb_byte;
          m_idx++;
          if (m_idx == 4) begin
            m_idx   = 0;
            mb_done = 1;
            mb_word = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
          end
        end
      end
      if (mb_done && m_dv && !rd_prev) m_ovf = 1;
      else if (mb_done) begin
        m_q  = mb_word;
        m_dv = 1;
        if (rd_prev) m_ovf = 0;
      end else if (rd_prev) begin
        m_dv  = 0;
        m_ovf = 0;
      end
      if (mb_bad) m_ferr = 1;
      else if (rd_prev) m_ferr = 0;
    end
    while (win_e.size() > 0 && win_e[0] <= cyc) begin
      void'(win_s.pop_front());
      void'(win_e.pop_front());
    end
    exp_busy = (win_s.size() > 0) && (win_s[0] <= cyc);
    chk("q",    q,    m_q);
    chk("dv",   dv,   m_dv);
    chk("ovf",  ovf,  m_ovf);
    chk("ferr", ferr, m_ferr);
    chk("busy", busy, exp_busy);
    rd_prev = rd;
    wb_prev = wrbaud;
    d_prev  = d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd = (cyc == rd_at) || (rd_rand && ($urandom_range(0, 15) == 0));
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000 && (ev_cyc.size() > 0 || win_s.size() > 0); i++) tick();
    if (i >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: receiver still pending after %0d cycles", i);
    end
  endtask

  task automatic settle();
    wait_idle();
    repeat (3) tick();
  endtask

  task automatic do_wrbaud(input bit mode, input int n);
    wait_idle();
    repeat (2) tick();
    d      = {mode, n[8:0]};
    wrbaud = 1'b1;
    tick();
    wrbaud = 1'b0;
    n_eff  = (n < 3) ? 3 : n;
    repeat (2) tick();
  endtask

  // Drives one frame; completion lands on posedge c0 + sync(2) + edge(1) + half + 1 + 9 bit times.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_len, input bit rd_hit);
    int c0, h, e;
    c0 = cyc;
    h  = n_eff >> 1;
    e  = c0 + 4 + h + 9 * (n_eff + 1);
    ev_cyc.push_back(e); ev_byte.push_back(b); ev_ok.push_back(stop_ok);
    win_s.push_back(c0 + 3); win_e.push_back(e);
    if (rd_hit) rd_at = e - 1;
    rxd = 1'b0;
    repeat (n_eff + 1) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (n_eff + 1) tick();
    end
    rxd = stop_ok;
    repeat (stop_len) tick();
    if (!stop_ok) begin
      rxd = 1'b1;
      repeat (n_eff + 1) tick();
    end
  endtask

  task automatic send_std(input logic [7:0] b);
    send_frame(b, 1'b1, n_eff + 1, 1'b0);
  endtask

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0; rxd = 1'b1; d = '0; wrbaud = 1'b0; rd = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_q", q, 32'h0);
    chk("rst_dv", dv, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_busy", busy, 0);

    // Normal mode, default divider
    send_std(8'h41); settle();
    chk("n41_q", q, 32'h00000041);
    chk("n41_dv", dv, 1);
    chk("n41_ferr", ferr, 0);
    pulse_rd(); settle();
    chk("n41_rd_dv", dv, 0);

    // Burst of four bytes
    do_wrbaud(1'b1, 7);
    send_std(8'h41); settle(); chk("b1_dv", dv, 0);
    send_std(8'h42); settle(); chk("b2_dv", dv, 0);
    send_std(8'h43); settle(); chk("b3_dv", dv, 0);
    send_std(8'h44); settle();
    chk("b4_dv", dv, 1);
    chk("b4_q", q, 32'h44434241);
    pulse_rd();

    // Overrun
    do_wrbaud(1'b0, 7);
    send_std(8'h42); send_std(8'h43); settle();
    chk("ovf_q", q, 32'h00000042);
    chk("ovf_flag", ovf, 1);
    pulse_rd(); settle();
    chk("ovf_rd_ovf", ovf, 0);
    chk("ovf_rd_dv", dv, 0);

    // Framing error in the middle of a burst
    do_wrbaud(1'b1, 7);
    send_std(8'hA1); send_std(8'hA2);
    send_frame(8'h55, 1'b0, 5, 1'b0);
    send_std(8'h11); send_std(8'h22); send_std(8'h33); send_std(8'h44); settle();
    chk("fe_ferr", ferr, 1);
    chk("fe_q", q, 32'h44332211);
    pulse_rd(); settle();

    // Glitch: false start returns to idle
    rxd = 1'b0;
    win_s.push_back(cyc + 3); win_e.push_back(cyc + 4 + (n_eff >> 1));
    repeat (2) tick();
    rxd = 1'b1;
    repeat (20) tick();
    chk("gl_dv", dv, 0);
    chk("gl_busy", busy, 0);

    // Reconfiguration mid-burst drops the partial word
    send_std(8'h01); send_std(8'h02);
    do_wrbaud(1'b0, 7);
    send_std(8'h5A); settle();
    chk("wb_q", q, 32'h0000005A);

    // rd coinciding with completion while dv=1
    send_std(8'h10); settle();
    send_frame(8'h20, 1'b1, n_eff + 1, 1'b1); settle();
    rd_at = -1;
    chk("sim_dv", dv, 1);
    chk("sim_q", q, 32'h00000020);
    chk("sim_ovf", ovf, 0);

    // Divider below minimum clamps to 3
    pulse_rd();
    do_wrbaud(1'b0, 1);
    send_frame(8'h96, 1'b1, 3, 1'b0); settle();
    chk("clamp_q", q, 32'h00000096);
    do_wrbaud(1'b0, 7);

    // Asynchronous reset mid-frame, line held low across release
    rxd = 1'b0;
    win_s.push_back(cyc + 3); win_e.push_back(32'h7fffffff);
    repeat (30) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("ar_q", q, 32'h0);
    chk("ar_dv", dv, 0);
    chk("ar_busy", busy, 0);
    rst_n = 1'b1;
    n_eff = 7;
    repeat (12) tick();
    chk("ar_low_busy", busy, 0);
    chk("ar_low_dv", dv, 0);
    rxd = 1'b1;
    repeat (12) tick();
    send_std(8'h3C); settle();
    chk("ar_q3c", q, 32'h0000003C);

    // Randomized frames, modes, dividers, framing errors and reads
    rd_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      bit bad;
      logic [7:0] b;
      if ($urandom_range(0, 6) == 0) do_wrbaud(1'($urandom_range(0, 1)), $urandom_range(0, 12));
      bad = ($urandom_range(0, 9) == 0);
      b   = 8'($urandom);
      send_frame(b, !bad, (n_eff >> 1) + 2 + $urandom_range(0, n_eff), 1'b0);
    end
    rd_rand = 1'b0;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
